// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has fixed priority over the multi-cycle unit.
// Define RF_ARB_STARVE_EN to enable the wait counter and the Stall_req bubble request.
module rf_write_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [31:0] WB_PD_in,
   input  logic [4:0]  WB_RD_in,
   input  logic        WB_RF_LE_in,
   input  logic        MC_valid,
   input  logic [4:0]  MC_RD,
   input  logic [31:0] MC_PD,
   output logic        MC_ready,
   output logic [31:0] RF_PW,
   output logic [4:0]  RF_RW,
   output logic        RF_LE,
   output logic        Stall_req
);

   logic        p_eff;
   logic        m_eff;
   logic [31:0] rf_pw_q, rf_pw_d;
   logic [4:0]  rf_rw_q, rf_rw_d;
   logic        rf_le_q, rf_le_d;

   // Writes to R0 are never effective, so they lose arbitration and leave RF_LE low.
   always_comb begin
      p_eff = WB_RF_LE_in && (WB_RD_in != 5'd0);
      m_eff = MC_valid && (MC_RD != 5'd0);
   end

   assign MC_ready = ~p_eff;

   always_comb begin
      rf_pw_d = rf_pw_q;
      rf_rw_d = rf_rw_q;
      rf_le_d = 1'b0;
      if (p_eff) begin
         rf_pw_d = WB_PD_in;
         rf_rw_d = WB_RD_in;
         rf_le_d = 1'b1;
      end else if (m_eff) begin
         rf_pw_d = MC_PD;
         rf_rw_d = MC_RD;
         rf_le_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         rf_pw_q <= 32'd0;
         rf_rw_q <= 5'd0;
         rf_le_q <= 1'b0;
      end else begin
         rf_pw_q <= rf_pw_d;
         rf_rw_q <= rf_rw_d;
         rf_le_q <= rf_le_d;
      end
   end

   assign RF_PW = rf_pw_q;
   assign RF_RW = rf_rw_q;
   assign RF_LE = rf_le_q;

`ifdef RF_ARB_STARVE_EN
   localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

   logic       m_xfer;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic       stall_q, stall_d;

   assign m_xfer = MC_valid & MC_ready;

   // Stall is registered alongside the counter so it rises in the cycle the counter hits the limit.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!MC_valid || m_xfer) begin
         wait_cnt_d = 4'd0;
      end else if (wait_cnt_q < Limit) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end
      stall_d = (wait_cnt_d == Limit);
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         wait_cnt_q <= 4'd0;
         stall_q    <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         stall_q    <= stall_d;
      end
   end

   assign Stall_req = stall_q;
`else
   assign Stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expectations queued at drive time, checked after the edge.
module tb_rf_write_arbiter;

   localparam int unsigned Limit = 4;
`ifdef RF_ARB_STARVE_EN
   localparam bit StarveEn = 1'b1;
`else
   localparam bit StarveEn = 1'b0;
`endif

   logic        clk;
   logic        Reset;
   logic [31:0] WB_PD_in;
   logic [4:0]  WB_RD_in;
   logic        WB_RF_LE_in;
   logic        MC_valid;
   logic [4:0]  MC_RD;
   logic [31:0] MC_PD;
   logic        MC_ready;
   logic [31:0] RF_PW;
   logic [4:0]  RF_RW;
   logic        RF_LE;
   logic        Stall_req;

   typedef struct packed {
      logic        le;
      logic [4:0]  rw;
      logic [31:0] pw;
      logic        stall;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   // Reference state
   logic [31:0] mdl_pw = '0;
   logic [4:0]  mdl_rw = '0;
   int unsigned mdl_cnt = 0;
   logic        last_ready = 1'b1;

   rf_write_arbiter #(.STARVE_LIMIT(Limit)) u_dut (
      .clk         (clk),
      .Reset       (Reset),
      .WB_PD_in    (WB_PD_in),
      .WB_RD_in    (WB_RD_in),
      .WB_RF_LE_in (WB_RF_LE_in),
      .MC_valid    (MC_valid),
      .MC_RD       (MC_RD),
      .MC_PD       (MC_PD),
      .MC_ready    (MC_ready),
      .RF_PW       (RF_PW),
      .RF_RW       (RF_RW),
      .RF_LE       (RF_LE),
      .Stall_req   (Stall_req)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_eq("rf_le", {31'd0, RF_LE}, {31'd0, e.le});
         check_eq("rf_rw", {27'd0, RF_RW}, {27'd0, e.rw});
         check_eq("rf_pw", RF_PW, e.pw);
         check_eq("stall_req", {31'd0, Stall_req}, {31'd0, e.stall});
      end
   end

   // Drives one cycle of stimulus, checks MC_ready and queues the post-edge expectation.
   task automatic drive(input logic ple, input logic [4:0] prd, input logic [31:0] ppd,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mpd);
      exp_t e;
      logic p_win, ready;
      @(negedge clk);
      WB_RF_LE_in = ple;
      WB_RD_in    = prd;
      WB_PD_in    = ppd;
      MC_valid    = mv;
      MC_RD       = mrd;
      MC_PD       = mpd;
      #1;
      p_win = ple && (prd != 5'd0);
      ready = !p_win;
      check_eq("mc_ready", {31'd0, MC_ready}, {31'd0, ready});
      e.le = 1'b0;
      if (p_win) begin
         e.le = 1'b1; mdl_rw = prd; mdl_pw = ppd;
      end else if (mv && (mrd != 5'd0)) begin
         e.le = 1'b1; mdl_rw = mrd; mdl_pw = mpd;
      end
      if (!mv || ready) mdl_cnt = 0;
      else if (mdl_cnt < Limit) mdl_cnt++;
      e.rw    = mdl_rw;
      e.pw    = mdl_pw;
      e.stall = StarveEn && (mdl_cnt == Limit);
      last_ready = ready;
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [4:0]  hrd;
      logic [31:0] hpd;
      logic        hv;
      Reset = 1'b0;
      WB_RF_LE_in = 1'b0; WB_RD_in = '0; WB_PD_in = '0;
      MC_valid = 1'b0; MC_RD = '0; MC_PD = '0;
      #2;
      check_eq("rst_le", {31'd0, RF_LE}, 32'd0);
      check_eq("rst_rw", {27'd0, RF_RW}, 32'd0);
      check_eq("rst_pw", RF_PW, 32'd0);
      check_eq("rst_stall", {31'd0, Stall_req}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      Reset = 1'b1;

      // Idle-M pipeline write
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      check_eq("p_only_le", {31'd0, RF_LE}, 32'd1);
      check_eq("p_only_rw", {27'd0, RF_RW}, 32'd5);
      check_eq("p_only_pw", RF_PW, 32'hDEADBEEF);

      // Idle-P multi-cycle write
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
      check_eq("m_only_rw", {27'd0, RF_RW}, 32'd7);
      check_eq("m_only_pw", RF_PW, 32'h12345678);

      // Collision then P drops
      drive(1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd9, 32'hBBBB0009);
      check_eq("coll_rw", {27'd0, RF_RW}, 32'd3);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hBBBB0009);
      check_eq("coll_m_rw", {27'd0, RF_RW}, 32'd9);
      check_eq("coll_m_pw", RF_PW, 32'hBBBB0009);

      // R0 discards: address/data hold
      drive(1'b1, 5'd0, 32'h0BAD0000, 1'b0, 5'd0, 32'd0);
      check_eq("p_r0_le", {31'd0, RF_LE}, 32'd0);
      check_eq("p_r0_rw", {27'd0, RF_RW}, 32'd9);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0BAD0001);
      check_eq("m_r0_le", {31'd0, RF_LE}, 32'd0);

      // Starvation: P streams while M waits
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 5'(10 + i), 32'hC0DE0000 + 32'(i), 1'b1, 5'd12, 32'hCAFE000C);
         if (i == 2) check_eq("stall_4th", {31'd0, Stall_req}, 32'd0);
         if (i == 3) check_eq("stall_5th", {31'd0, Stall_req}, {31'd0, StarveEn});
      end
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hCAFE000C);
      check_eq("bubble_rw", {27'd0, RF_RW}, 32'd12);
      check_eq("bubble_stall", {31'd0, Stall_req}, 32'd0);

      // Async reset between edges with a collision in flight
      WB_RF_LE_in = 1'b1; WB_RD_in = 5'd3; WB_PD_in = 32'h11110003;
      MC_valid = 1'b1; MC_RD = 5'd9; MC_PD = 32'h22220009;
      #1;
      Reset = 1'b0;
      #1;
      check_eq("arst_le", {31'd0, RF_LE}, 32'd0);
      check_eq("arst_rw", {27'd0, RF_RW}, 32'd0);
      check_eq("arst_pw", RF_PW, 32'd0);
      check_eq("arst_stall", {31'd0, Stall_req}, 32'd0);
      check_eq("arst_ready", {31'd0, MC_ready}, 32'd0);
      mdl_pw = '0; mdl_rw = '0; mdl_cnt = 0;
      @(negedge clk);
      @(negedge clk);
      Reset = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h22220009);
      check_eq("post_rst_rw", {27'd0, RF_RW}, 32'd9);

      // Random traffic; M holds its request while not accepted
      hv = 1'b0; hrd = '0; hpd = '0;
      last_ready = 1'b1;
      for (int i = 0; i < 80; i++) begin
         if (!(hv && !last_ready)) begin
            hv  = ($urandom_range(0, 3) != 0);
            hrd = 5'($urandom_range(0, 7));
            hpd = $urandom;
         end
         drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom, hv, hrd, hpd);
      end

      @(negedge clk);
      check_eq("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_LIMIT, default 4: wait cycles before a stall request is raised (legal range 1..15).
REQ-002 The module SHALL have these ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- Reset, input, 1: asynchronous, active-low reset.
- WB_PD_in, input, 32: pipeline write-back data.
- WB_RD_in, input, 5: pipeline destination register.
- WB_RF_LE_in, input, 1: pipeline write request.
- MC_valid, input, 1: multi-cycle unit write request.
- MC_RD, input, 5: multi-cycle unit destination register.
- MC_PD, input, 32: multi-cycle unit write data.
- MC_ready, output, 1: multi-cycle write accepted this cycle.
- RF_PW, output, 32: register-file write data.
- RF_RW, output, 5: register-file write address.
- RF_LE, output, 1: register-file write enable.
- Stall_req, output, 1: request to the pipeline for one write-back bubble.

Function
REQ-003 The block SHALL arbitrate the single register-file write port between the pipeline write-back stream (P) and the multi-cycle unit (M).
REQ-004 P request is "effective" when WB_RF_LE_in=1 and WB_RD_in!=0; M request is effective when MC_valid=1 and MC_RD!=0.
REQ-005 P has fixed priority and is never back-pressured; an effective P request always wins.
REQ-006 MC_ready SHALL be combinational, equal to NOT(effective P request), independent of MC_valid.
REQ-007 An M transfer completes on any cycle with MC_valid=1 and MC_ready=1.
REQ-008 M SHALL hold MC_RD/MC_PD stable while MC_valid=1 and MC_ready=0; the arbiter does not buffer M.
REQ-009 Writes to register 0 (either source) SHALL be discarded with RF_LE=0; an M write to R0 still completes the handshake (MC_ready per REQ-006).
REQ-010 RF_PW/RF_RW/RF_LE SHALL be registered: the winner's data/address/enable appear exactly 1 cycle after the grant cycle.
REQ-011 When no source wins, RF_LE=0 and RF_PW/RF_RW hold their previous values.
REQ-012 A 4-bit wait counter SHALL increment on each cycle with MC_valid=1 and MC_ready=0, saturating at STARVE_LIMIT.
REQ-013 The wait counter SHALL clear on an M transfer, or on any cycle with MC_valid=0.
REQ-014 Stall_req SHALL be registered and equal 1 in every cycle after the counter equals STARVE_LIMIT, until the counter clears.
REQ-015 The pipeline is expected to honour Stall_req by presenting WB_RF_LE_in=0; if it does not, priority per REQ-005 still holds and Stall_req stays asserted.
REQ-016 Simultaneous effective P and M requests: P is written and M waits; the counter increments.
REQ-017 Assertion of Reset mid-transfer SHALL drop any grant in flight; the registered write is lost and M must re-present after reset.

Reset
REQ-018 While Reset=0, outputs SHALL be asynchronously forced to RF_PW=0, RF_RW=0, RF_LE=0, Stall_req=0, and the wait counter to 0.
REQ-019 MC_ready during reset follows REQ-006 combinationally; no transfer is counted while Reset=0.
REQ-020 Normal operation SHALL resume on the first rising clk edge after Reset returns to 1.

Configuration
REQ-021 Macro RF_ARB_STARVE_EN defined: the wait counter and Stall_req SHALL behave per REQ-012..REQ-014.
REQ-022 Macro RF_ARB_STARVE_EN undefined: the counter SHALL not exist, Stall_req SHALL be tied 0, and arbitration is otherwise identical.

Verification
REQ-023 Idle-M P write: P writes R5=0xDEADBEEF, MC_valid=0 -> next cycle RF_LE=1, RF_RW=5, RF_PW=0xDEADBEEF.
REQ-024 Idle-P M write: WB_RF_LE_in=0, M writes R7=0x12345678 -> MC_ready=1 same cycle; next cycle RF_RW=7, RF_PW=0x12345678.
REQ-025 Collision, then P drops: P R3 and M R9 asserted together -> R3 written, MC_ready=0, M held. P then drops -> R9 written one cycle later.
REQ-026 Starvation (STARVE_LIMIT=4, macro defined): P writes continuously with M valid -> Stall_req=1 from the 5th cycle onward. P bubble -> M accepted, Stall_req=0 the next cycle.
REQ-027 R0 discard and async reset:
- P writes R0 -> RF_LE=0.
- M to R0 -> handshake completes with RF_LE=0.
- Reset=0 asserted between edges -> all outputs 0 immediately, without a clock edge.
